// File: rtl/vm2002_vend_ctrl.sv
`default_nettype none
// ============================================================================
// Module : vm2002_vend_ctrl
// Purchase controller: coin intake, inventory lookup, vend and change return.
// Rev    : 1.0
// ============================================================================
module vm2002_vend_ctrl #(
  parameter int MAX_BALANCE = 2000,
  parameter int TIMEOUT     = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        coin_valid,
  input  logic [1:0]  coin_val,
  output logic        coin_reject,
  input  logic        select,
  input  logic [2:0]  item_sel,
  input  logic        cancel,
  output logic        inv_rd,
  output logic [2:0]  inv_item,
  input  logic [4:0]  inv_count,
  input  logic [7:0]  inv_cost,
  output logic        inv_dec,
  output logic        dispense,
  output logic [2:0]  product,
  output logic [2:0]  status,
  output logic [15:0] balance,
  output logic        change_valid,
  output logic [15:0] change_amt,
  input  logic        change_ack,
  output logic [7:0]  info
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);

  localparam logic [2:0] c_stat_idle    = 3'd0;
  localparam logic [2:0] c_stat_collect = 3'd1;
  localparam logic [2:0] c_stat_vended  = 3'd2;
  localparam logic [2:0] c_stat_soldout = 3'd3;
  localparam logic [2:0] c_stat_insuff  = 3'd4;
  localparam logic [2:0] c_stat_refund  = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_COLLECT = 3'd1,
    S_LOOKUP  = 3'd2,
    S_CHECK   = 3'd3,
    S_VEND    = 3'd4,
    S_CHANGE  = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic [15:0]        balance_q, balance_d;
  logic [2:0]         status_q, status_d;
  logic [2:0]         item_q, item_d;
  logic [7:0]         cost_q, cost_d;
  logic [7:0]         info_q, info_d;
  logic [2:0]         product_q, product_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic               change_valid_q, change_valid_d;
  logic               inv_rd_q, inv_rd_d;
  logic               inv_dec_q, inv_dec_d;
  logic               dispense_q, dispense_d;
  logic               coin_reject_q, coin_reject_d;

  logic [6:0]         w_coin_cents;
  logic [16:0]        w_coin_sum;
  logic               w_coin_ok;
  logic [15:0]        w_vend_bal;

  always_comb begin
    w_coin_cents = 7'd5;
    unique case (coin_val)
      2'd0: w_coin_cents = 7'd5;
      2'd1: w_coin_cents = 7'd10;
      2'd2: w_coin_cents = 7'd25;
      2'd3: w_coin_cents = 7'd100;
    endcase
  end

  assign w_coin_sum = {1'b0, balance_q} + {10'd0, w_coin_cents};
  assign w_coin_ok  = coin_valid && ((state_q == S_IDLE) || (state_q == S_COLLECT))
                      && (w_coin_sum <= 17'(MAX_BALANCE));
  assign w_vend_bal = balance_q - {8'd0, cost_q};

  always_comb begin
    state_d        = state_q;
    balance_d      = balance_q;
    status_d       = status_q;
    item_d         = item_q;
    cost_d         = cost_q;
    info_d         = info_q;
    product_d      = product_q;
    tmo_d          = '0;
    change_valid_d = change_valid_q;
    inv_rd_d       = 1'b0;
    inv_dec_d      = 1'b0;
    dispense_d     = 1'b0;
    coin_reject_d  = coin_valid && !w_coin_ok;

    if (w_coin_ok) begin
      balance_d = w_coin_sum[15:0];
      status_d  = c_stat_collect;
    end

    unique case (state_q)
      S_IDLE: begin
        if (w_coin_ok) state_d = S_COLLECT;
      end
      S_COLLECT: begin
        // A coin landing with cancel/select is still credited above.
        if (cancel) begin
          state_d        = S_CHANGE;
          status_d       = c_stat_refund;
          change_valid_d = 1'b1;
        end else if (select) begin
          item_d   = item_sel;
          inv_rd_d = 1'b1;
          state_d  = S_LOOKUP;
        end else if (coin_valid) begin
          tmo_d = '0;
        end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
          state_d        = S_CHANGE;
          status_d       = c_stat_refund;
          change_valid_d = 1'b1;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_LOOKUP: begin
        state_d = S_CHECK;
      end
      S_CHECK: begin
        if (inv_count == 5'd0) begin
          status_d = c_stat_soldout;
          info_d   = {item_q, 5'd0};
          state_d  = S_COLLECT;
        end else if ({8'd0, inv_cost} > balance_q) begin
          status_d = c_stat_insuff;
          info_d   = {item_q, inv_count};
          state_d  = S_COLLECT;
        end else begin
          cost_d     = inv_cost;
          inv_dec_d  = 1'b1;
          dispense_d = 1'b1;
          product_d  = item_q;
          info_d     = {item_q, inv_count - 5'd1};
          status_d   = c_stat_vended;
          state_d    = S_VEND;
        end
      end
      S_VEND: begin
        balance_d = w_vend_bal;
        if (w_vend_bal != 16'd0) begin
          state_d        = S_CHANGE;
          change_valid_d = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CHANGE: begin
        if (change_ack) begin
          balance_d      = 16'd0;
          change_valid_d = 1'b0;
          state_d        = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      balance_q      <= 16'd0;
      status_q       <= c_stat_idle;
      item_q         <= 3'd0;
      cost_q         <= 8'd0;
      info_q         <= 8'd0;
      product_q      <= 3'd0;
      tmo_q          <= '0;
      change_valid_q <= 1'b0;
      inv_rd_q       <= 1'b0;
      inv_dec_q      <= 1'b0;
      dispense_q     <= 1'b0;
      coin_reject_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      balance_q      <= balance_d;
      status_q       <= status_d;
      item_q         <= item_d;
      cost_q         <= cost_d;
      info_q         <= info_d;
      product_q      <= product_d;
      tmo_q          <= tmo_d;
      change_valid_q <= change_valid_d;
      inv_rd_q       <= inv_rd_d;
      inv_dec_q      <= inv_dec_d;
      dispense_q     <= dispense_d;
      coin_reject_q  <= coin_reject_d;
    end
  end

  assign coin_reject  = coin_reject_q;
  assign inv_rd       = inv_rd_q;
  assign inv_item     = item_q;
  assign inv_dec      = inv_dec_q;
  assign dispense     = dispense_q;
  assign product      = product_q;
  assign status       = status_q;
  assign balance      = balance_q;
  assign change_valid = change_valid_q;
  // Balance is frozen while in CHANGE, so it doubles as the change amount.
  assign change_amt   = change_valid_q ? balance_q : 16'd0;
  assign info         = info_q;

endmodule
`default_nettype wire

// File: tb/tb_vm2002_vend_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_vm2002_vend_ctrl
// Self-checking bench for vm2002_vend_ctrl with a transaction-level model.
// Rev    : 1.0
// ============================================================================
module tb_vm2002_vend_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        coin_valid = 1'b0;
  logic [1:0]  coin_val = 2'd0;
  logic        coin_reject;
  logic        select = 1'b0;
  logic [2:0]  item_sel = 3'd0;
  logic        cancel = 1'b0;
  logic        inv_rd;
  logic [2:0]  inv_item;
  logic [4:0]  inv_count;
  logic [7:0]  inv_cost;
  logic        inv_dec;
  logic        dispense;
  logic [2:0]  product;
  logic [2:0]  status;
  logic [15:0] balance;
  logic        change_valid;
  logic [15:0] change_amt;
  logic        change_ack = 1'b0;
  logic [7:0]  info;

  int total  = 0;
  int passed = 0;

  // Inventory store (supplier side), written only by the responder block.
  logic        cfg_we = 1'b0;
  logic [2:0]  cfg_item = 3'd0;
  logic [4:0]  cfg_cnt = 5'd0;
  logic [7:0]  cfg_cost = 8'd0;
  logic [4:0]  mem_cnt [8];
  logic [7:0]  mem_cost [8];

  // Reference model state.
  int          m_bal;
  int          m_stock [8];
  int          m_cost [8];
  logic [2:0]  m_status;

  vm2002_vend_ctrl #(.MAX_BALANCE(2000), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .coin_valid(coin_valid), .coin_val(coin_val), .coin_reject(coin_reject),
    .select(select), .item_sel(item_sel), .cancel(cancel),
    .inv_rd(inv_rd), .inv_item(inv_item), .inv_count(inv_count), .inv_cost(inv_cost),
    .inv_dec(inv_dec), .dispense(dispense), .product(product), .status(status),
    .balance(balance), .change_valid(change_valid), .change_amt(change_amt),
    .change_ack(change_ack), .info(info)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (cfg_we) begin
      mem_cnt[cfg_item]  <= cfg_cnt;
      mem_cost[cfg_item] <= cfg_cost;
    end else if (inv_dec && mem_cnt[inv_item] != 5'd0) begin
      mem_cnt[inv_item] <= mem_cnt[inv_item] - 5'd1;
    end
    if (inv_rd) begin
      inv_count <= mem_cnt[inv_item];
      inv_cost  <= mem_cost[inv_item];
    end
  end

  function automatic int cents(input logic [1:0] cv);
    case (cv)
      2'd0: return 5;
      2'd1: return 10;
      2'd2: return 25;
      default: return 100;
    endcase
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; tick(); tick(); rst = 1'b0;
  endtask

  task automatic set_item(input logic [2:0] it, input int cnt, input int cst);
    cfg_item = it; cfg_cnt = 5'(cnt); cfg_cost = 8'(cst); cfg_we = 1'b1;
    tick(); cfg_we = 1'b0;
    m_stock[it] = cnt; m_cost[it] = cst;
  endtask

  task automatic coin(input logic [1:0] cv);
    coin_valid = 1'b1; coin_val = cv; tick(); coin_valid = 1'b0;
  endtask

  task automatic do_select(input logic [2:0] it);
    select = 1'b1; item_sel = it; tick(); select = 1'b0;
  endtask

  task automatic ack();
    change_ack = 1'b1; tick(); change_ack = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if ({coin_reject, inv_rd, inv_item, inv_dec, dispense, product, status, balance,
                  change_valid, change_amt, info} !== 54'd0)
      $display("FAIL reset_outputs: got status=%0d bal=%0d cv=%0d info=%h want all zero",
               status, balance, change_valid, info);
    else passed++;
  endtask

  task automatic test_vend_change();
    set_item(3'd2, 5, 75);
    coin(2'd3); coin(2'd2);
    total++; if (balance !== 16'd125) $display("FAIL vc_balance: got %0d want 125", balance); else passed++;
    total++; if (status !== 3'd1) $display("FAIL vc_status_collect: got %0d want 1", status); else passed++;
    do_select(3'd2);
    total++; if ({inv_rd, inv_item, dispense} !== {1'b1, 3'd2, 1'b0})
      $display("FAIL vc_inv_rd: got rd=%0d item=%0d disp=%0d want 1 2 0", inv_rd, inv_item, dispense);
    else passed++;
    tick();
    total++; if (inv_rd !== 1'b0) $display("FAIL vc_inv_rd_width: got %0d want 0", inv_rd); else passed++;
    tick();
    total++; if ({dispense, inv_dec, product, info, status} !== {1'b1, 1'b1, 3'd2, 8'h44, 3'd2})
      $display("FAIL vc_vend: got disp=%0d dec=%0d prod=%0d info=%h st=%0d want 1 1 2 44 2",
               dispense, inv_dec, product, info, status);
    else passed++;
    tick();
    total++; if ({dispense, change_valid, change_amt} !== {1'b0, 1'b1, 16'd50})
      $display("FAIL vc_change: got disp=%0d cv=%0d amt=%0d want 0 1 50", dispense, change_valid, change_amt);
    else passed++;
    ack();
    total++; if ({change_valid, balance, status} !== {1'b0, 16'd0, 3'd2})
      $display("FAIL vc_after_ack: got cv=%0d bal=%0d st=%0d want 0 0 2", change_valid, balance, status);
    else passed++;
    do_select(3'd2);
    total++; if (inv_rd !== 1'b0) $display("FAIL vc_idle_select: got rd=%0d want 0", inv_rd); else passed++;
  endtask

  task automatic test_insufficient();
    set_item(3'd1, 3, 75);
    coin(2'd2); coin(2'd2);
    do_select(3'd1); tick(); tick();
    total++; if ({status, inv_dec, dispense, info, balance} !== {3'd4, 1'b0, 1'b0, 8'h23, 16'd50})
      $display("FAIL ins_check: got st=%0d dec=%0d disp=%0d info=%h bal=%0d want 4 0 0 23 50",
               status, inv_dec, dispense, info, balance);
    else passed++;
    coin(2'd2);
    do_select(3'd1); tick(); tick();
    total++; if ({dispense, status} !== {1'b1, 3'd2})
      $display("FAIL ins_revend: got disp=%0d st=%0d want 1 2", dispense, status);
    else passed++;
    tick();
    total++; if ({balance, change_valid} !== {16'd0, 1'b0})
      $display("FAIL ins_no_change: got bal=%0d cv=%0d want 0 0", balance, change_valid);
    else passed++;
  endtask

  task automatic test_sold_out_cancel();
    set_item(3'd7, 0, 50);
    coin(2'd3);
    do_select(3'd7); tick(); tick();
    total++; if ({status, info, balance, dispense} !== {3'd3, 8'hE0, 16'd100, 1'b0})
      $display("FAIL so_check: got st=%0d info=%h bal=%0d disp=%0d want 3 e0 100 0",
               status, info, balance, dispense);
    else passed++;
    cancel = 1'b1; tick(); cancel = 1'b0;
    total++; if ({status, change_valid, change_amt} !== {3'd5, 1'b1, 16'd100})
      $display("FAIL so_refund: got st=%0d cv=%0d amt=%0d want 5 1 100", status, change_valid, change_amt);
    else passed++;
    ack();
    total++; if ({change_valid, balance} !== {1'b0, 16'd0})
      $display("FAIL so_after_ack: got cv=%0d bal=%0d want 0 0", change_valid, balance);
    else passed++;
  endtask

  task automatic test_max_balance();
    set_item(3'd4, 2, 10);
    repeat (19) coin(2'd3);
    repeat (2) coin(2'd2);
    total++; if (balance !== 16'd1950) $display("FAIL max_fill: got %0d want 1950", balance); else passed++;
    coin(2'd3);
    total++; if ({coin_reject, balance} !== {1'b1, 16'd1950})
      $display("FAIL max_reject: got rej=%0d bal=%0d want 1 1950", coin_reject, balance);
    else passed++;
    tick();
    total++; if (coin_reject !== 1'b0) $display("FAIL max_reject_width: got %0d want 0", coin_reject); else passed++;
    coin(2'd2);
    total++; if ({coin_reject, balance} !== {1'b0, 16'd1975})
      $display("FAIL max_accept: got rej=%0d bal=%0d want 0 1975", coin_reject, balance);
    else passed++;
    do_select(3'd4); tick();
    coin(2'd0);
    total++; if ({coin_reject, dispense, balance} !== {1'b1, 1'b1, 16'd1975})
      $display("FAIL max_check_coin: got rej=%0d disp=%0d bal=%0d want 1 1 1975", coin_reject, dispense, balance);
    else passed++;
    tick();
    total++; if ({balance, change_valid, change_amt} !== {16'd1965, 1'b1, 16'd1965})
      $display("FAIL max_change: got bal=%0d cv=%0d amt=%0d want 1965 1 1965", balance, change_valid, change_amt);
    else passed++;
    ack();
  endtask

  task automatic test_same_cycle();
    set_item(3'd3, 4, 75);
    coin(2'd2); coin(2'd2);
    coin_valid = 1'b1; coin_val = 2'd2; select = 1'b1; item_sel = 3'd3;
    tick();
    coin_valid = 1'b0; select = 1'b0;
    total++; if ({inv_rd, balance} !== {1'b1, 16'd75})
      $display("FAIL sc_coin_select: got rd=%0d bal=%0d want 1 75", inv_rd, balance);
    else passed++;
    tick(); tick();
    total++; if (dispense !== 1'b1) $display("FAIL sc_vend: got %0d want 1", dispense); else passed++;
    tick();
    total++; if ({balance, change_valid} !== {16'd0, 1'b0})
      $display("FAIL sc_idle: got bal=%0d cv=%0d want 0 0", balance, change_valid);
    else passed++;
    coin(2'd1);
    cancel = 1'b1; select = 1'b1; item_sel = 3'd3;
    tick();
    cancel = 1'b0; select = 1'b0;
    total++; if ({inv_rd, status, change_valid, change_amt} !== {1'b0, 3'd5, 1'b1, 16'd10})
      $display("FAIL sc_cancel_select: got rd=%0d st=%0d cv=%0d amt=%0d want 0 5 1 10",
               inv_rd, status, change_valid, change_amt);
    else passed++;
    ack();
  endtask

  task automatic test_timeout_reset();
    coin(2'd1);
    repeat (7) tick();
    total++; if (change_valid !== 1'b0) $display("FAIL to_early: got cv=%0d want 0", change_valid); else passed++;
    tick();
    total++; if ({change_valid, change_amt, status} !== {1'b1, 16'd10, 3'd5})
      $display("FAIL to_refund: got cv=%0d amt=%0d st=%0d want 1 10 5", change_valid, change_amt, status);
    else passed++;
    rst = 1'b1; tick(); rst = 1'b0;
    total++; if ({coin_reject, inv_rd, inv_item, inv_dec, dispense, product, status, balance,
                  change_valid, change_amt, info} !== 54'd0)
      $display("FAIL to_mid_reset: got st=%0d bal=%0d cv=%0d amt=%0d want all zero",
               status, balance, change_valid, change_amt);
    else passed++;
  endtask

  task automatic test_random();
    int unsigned op;
    logic [2:0]  it;
    logic [1:0]  cv;
    int          v;
    do_reset();
    m_bal = 0; m_status = 3'd0;
    for (int i = 0; i < 8; i++)
      set_item(3'(i), int'($urandom_range(0, 3)), 5 * int'($urandom_range(1, 50)));
    for (int n = 0; n < 200; n++) begin
      op = $urandom_range(0, 99);
      if (op < 55) begin
        cv = 2'($urandom_range(0, 3));
        v  = cents(cv);
        coin(cv);
        if (m_bal + v <= 2000) begin
          m_bal += v; m_status = 3'd1;
          total++; if (coin_reject !== 1'b0) $display("FAIL rnd_coin_accept: got rej=%0d want 0", coin_reject); else passed++;
        end else begin
          total++; if (coin_reject !== 1'b1) $display("FAIL rnd_coin_reject: got rej=%0d want 1", coin_reject); else passed++;
        end
        total++; if ({balance, status} !== {16'(m_bal), m_status})
          $display("FAIL rnd_coin_state: got bal=%0d st=%0d want %0d %0d", balance, status, m_bal, m_status);
        else passed++;
      end else if (op < 88) begin
        it = 3'($urandom_range(0, 7));
        do_select(it);
        if (m_bal == 0) begin
          total++; if (inv_rd !== 1'b0) $display("FAIL rnd_idle_select: got rd=%0d want 0", inv_rd); else passed++;
        end else begin
          total++; if ({inv_rd, inv_item} !== {1'b1, it})
            $display("FAIL rnd_lookup: got rd=%0d item=%0d want 1 %0d", inv_rd, inv_item, it);
          else passed++;
          tick(); tick();
          if (m_stock[it] == 0) begin
            m_status = 3'd3;
            total++; if ({dispense, status, info} !== {1'b0, m_status, it, 5'd0})
              $display("FAIL rnd_soldout: got disp=%0d st=%0d info=%h want 0 3 item %0d", dispense, status, info, it);
            else passed++;
          end else if (m_bal < m_cost[it]) begin
            m_status = 3'd4;
            total++; if ({dispense, status, info} !== {1'b0, m_status, it, 5'(m_stock[it])})
              $display("FAIL rnd_insuff: got disp=%0d st=%0d info=%h want 0 4 stock %0d", dispense, status, info, m_stock[it]);
            else passed++;
          end else begin
            m_status = 3'd2;
            total++; if ({dispense, inv_dec, product, status, info} !==
                         {1'b1, 1'b1, it, m_status, it, 5'(m_stock[it] - 1)})
              $display("FAIL rnd_vend: got disp=%0d dec=%0d prod=%0d st=%0d info=%h want item %0d stock %0d",
                       dispense, inv_dec, product, status, info, it, m_stock[it] - 1);
            else passed++;
            m_stock[it] -= 1;
            m_bal -= m_cost[it];
            tick();
            if (m_bal > 0) begin
              total++; if ({change_valid, change_amt} !== {1'b1, 16'(m_bal)})
                $display("FAIL rnd_change: got cv=%0d amt=%0d want 1 %0d", change_valid, change_amt, m_bal);
              else passed++;
              ack();
              m_bal = 0;
            end else begin
              total++; if (change_valid !== 1'b0) $display("FAIL rnd_exact: got cv=%0d want 0", change_valid); else passed++;
            end
          end
          total++; if ({balance, status} !== {16'(m_bal), m_status})
            $display("FAIL rnd_select_state: got bal=%0d st=%0d want %0d %0d", balance, status, m_bal, m_status);
          else passed++;
        end
      end else begin
        cancel = 1'b1; tick(); cancel = 1'b0;
        if (m_bal == 0) begin
          total++; if (change_valid !== 1'b0) $display("FAIL rnd_idle_cancel: got cv=%0d want 0", change_valid); else passed++;
        end else begin
          m_status = 3'd5;
          total++; if ({change_valid, change_amt, status} !== {1'b1, 16'(m_bal), m_status})
            $display("FAIL rnd_refund: got cv=%0d amt=%0d st=%0d want 1 %0d 5", change_valid, change_amt, status, m_bal);
          else passed++;
          ack();
          m_bal = 0;
          total++; if ({change_valid, balance} !== {1'b0, 16'd0})
            $display("FAIL rnd_refund_ack: got cv=%0d bal=%0d want 0 0", change_valid, balance);
          else passed++;
        end
      end
    end
  endtask

  initial begin
    tick();
    test_reset();
    test_vend_change();
    test_insufficient();
    test_sold_out_cancel();
    test_max_balance();
    test_same_cycle();
    test_timeout_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running want finished");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/vm2002_vend_ctrl.md
Name: vm2002_vend_ctrl

Overview:
User-side purchase controller for vm2002. It accepts coins, latches a product selection, and reads stock and cost from the inventory store that the supplier restock logic writes. It then either vends and decrements stock, or reports sold-out or insufficient funds, and returns change through an ack handshake. It is the reader/consumer end of the inventory interface.

Parameters:
MAX_BALANCE, 2000, maximum accepted balance in cents; any coin that would exceed it is rejected.
TIMEOUT, 1000, idle cycles in COLLECT, with no coin or select, before an automatic refund.

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
coin_valid  in  1  one-cycle coin strobe
coin_val  in  2  coin denomination: 0=5c, 1=10c, 2=25c, 3=100c
coin_reject  out  1  one-cycle pulse when a coin is refused
select  in  1  one-cycle purchase strobe
item_sel  in  3  item code, sampled with select
cancel  in  1  one-cycle refund request
inv_rd  out  1  inventory read strobe
inv_item  out  3  item code for the read and the decrement
inv_count  in  5  stock count (0..16); valid the cycle after inv_rd
inv_cost  in  8  item cost in cents; valid the cycle after inv_rd
inv_dec  out  1  one-cycle decrement-by-1 of inv_item
dispense  out  1  one-cycle vend pulse
product  out  3  last vended item code
status  out  3  0 IDLE, 1 COLLECT, 2 VENDED, 3 SOLD_OUT, 4 INSUFFICIENT, 5 REFUND
balance  out  16  current credit in cents
change_valid  out  1  change offer; held until change_ack
change_amt  out  16  change in cents; stable while change_valid
change_ack  in  1  change taken
info  out  8  {item[2:0], remaining stock[4:0]} of the last lookup

Behaviour:
- Reset: state IDLE; all outputs 0; timeout counter 0. rst overrides everything, including mid-transaction; any pending change is discarded.
- Coin values map 5/10/25/100. A coin is accepted only in IDLE or COLLECT, and only if balance+value <= MAX_BALANCE. Otherwise coin_reject pulses the following cycle and balance is unchanged.
- Accepted coin: balance updates the next cycle. In IDLE, an accepted coin also moves the FSM to COLLECT (status=1).
- IDLE: select or cancel with balance=0 is ignored.
- COLLECT priorities: cancel > select > timeout.
  - cancel: go to CHANGE with status=REFUND.
  - select: latch item_sel and go to LOOKUP. If a coin arrives in the same cycle, the coin is accepted and the lookup uses the updated balance.
  - Timeout: the counter resets on every coin. When it reaches TIMEOUT-1, go to CHANGE with status=REFUND.
- LOOKUP (1 cycle): inv_rd=1, inv_item=latched item. Go to CHECK.
- CHECK (inventory data valid):
  - inv_count==0: status=SOLD_OUT, info={item,0}, return to COLLECT.
  - Otherwise, if balance<inv_cost: status=INSUFFICIENT, info={item,inv_count}, return to COLLECT.
  - Otherwise go to VEND.
- VEND (1 cycle): inv_dec=1, dispense=1, product=item, balance<=balance-inv_cost, info={item,inv_count-1}, status=VENDED.
  - Next state is CHANGE if the new balance >0, else IDLE.
  - Cost is captured in CHECK; the 16-bit subtraction never underflows.
- CHANGE: change_valid=1, change_amt=balance. On the cycle change_ack=1: balance<=0, change_valid<=0, go to IDLE.
  - status stays VENDED or REFUND until the next coin.
  - change_ack outside CHANGE is ignored.
- Coins arriving in LOOKUP/CHECK/VEND/CHANGE are rejected (coin_reject pulse). select and cancel are ignored outside IDLE and COLLECT.
- Pulse outputs (inv_rd, inv_dec, dispense, coin_reject) are registered and exactly one cycle wide.
- Latency from select to dispense: 3 cycles (LOOKUP, CHECK, VEND).

Test Plan:
- Reset, then coins 100+25 (balance 125), select item 2 with cost 75 and count 5 -> inv_rd 1 cycle after select; dispense and inv_dec 3 cycles after select; product=2; info=0x44; change_valid with change_amt=50; after ack, balance=0 and state IDLE.
- Balance 50, select item 1 with cost 75 -> status=INSUFFICIENT, no inv_dec, balance stays 50; add 25, reselect -> vend, balance 0, back to IDLE with no CHANGE.
- Select item 7 with count 0 -> status=SOLD_OUT, info=0xE0, balance unchanged; cancel -> status=REFUND, change_amt equals the prior balance.
- Balance 1950 (MAX_BALANCE=2000), insert 100 -> coin_reject pulse, balance 1950; insert 25 -> balance 1975. A coin during CHECK is also rejected.
- Same-cycle coin(25) and select with balance 50 and cost 75 -> vend succeeds. Same-cycle cancel and select -> refund, no inv_rd.
- TIMEOUT=8: coin 10, then 8 idle cycles -> CHANGE with change_amt=10. Asserting rst while change_valid is high -> all outputs 0 the next cycle.
